aes_round_ctrl: RTL

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_step_watchdog.sv | 29 ++
 rtl/aes_round_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round-sequencing controller:
// FSM state encoding, round counts per key size and the key_len encoding.
package aes_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARK0,
        S_SUB,
        S_SHIFT,
        S_MIX,
        S_ARK,
        S_DONE,
        S_ERR
    } aes_state_t;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [1:0] {
        KEY_128  = 2'b00,
        KEY_192  = 2'b01,
        KEY_256  = 2'b10,
        KEY_RSVD = 2'b11
    } aes_keylen_t;

    // The reserved encoding falls back to the 128-bit round count.
    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        logic [3:0] nr;
        case (kl)
            KEY_192: nr = NR_192;
            KEY_256: nr = NR_256;
            default: nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_step_watchdog.sv
// Per-step wait counter: counts ticks since the last clear and flags
// expiry on the tick that would exhaust the allowed wait.
module aes_step_watchdog #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (tick && cnt != limit)
            cnt <= cnt + W'(1);
    end

    // Fires during the limit-th waiting cycle so the FSM leaves the step
    // after exactly 'limit' cycles without a done.
    assign expired = tick && (cnt == limit - W'(1));

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: ARK0, then (SUB, SHIFT, MIX, ARK) per round with MIX
// skipped in the last round, plus a per-step watchdog.
// Define AES_KEYLEN_SEL_EN to add the key_len port (10/12/14 rounds).
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
`ifdef AES_KEYLEN_SEL_EN
    input  logic [1:0] key_len,
`endif
    input  logic       sub_done,
    input  logic       shift_done,
    input  logic       mix_done,
    input  logic       ark_done,
    output logic       sub_en,
    output logic       shift_en,
    output logic       mix_en,
    output logic       ark_en,
    output logic [3:0] round_idx,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    aes_state_t state, state_nxt;
    logic [3:0] idx_nxt;
    logic [3:0] nr;
    logic       in_step, own_done, step_tick, wd_expired, wd_clear;
    logic       accept;

    assign accept = start && (state == S_IDLE || state == S_ERR);

`ifdef AES_KEYLEN_SEL_EN
    logic [3:0] nr_q;
    always_ff @(posedge clk) begin
        if (reset)
            nr_q <= NR_128;
        else if (accept)
            nr_q <= nr_of(key_len);
    end
    assign nr = nr_q;
`else
    assign nr = NR_128;
`endif

    // Only the active step's own done counts; other done lines are ignored.
    always_comb begin
        own_done = 1'b0;
        case (state)
            S_ARK0, S_ARK: own_done = ark_done;
            S_SUB:         own_done = sub_done;
            S_SHIFT:       own_done = shift_done;
            S_MIX:         own_done = mix_done;
            default:       own_done = 1'b0;
        endcase
    end

    assign in_step   = state inside {S_ARK0, S_SUB, S_SHIFT, S_MIX, S_ARK};
    assign step_tick = in_step && !own_done;

    always_comb begin
        state_nxt = state;
        idx_nxt   = round_idx;
        case (state)
            S_IDLE, S_ERR: if (start) begin
                state_nxt = S_ARK0;
                idx_nxt   = 4'd0;
            end
            S_ARK0: if (own_done) begin
                state_nxt = S_SUB;
                idx_nxt   = 4'd1;
            end
            S_SUB:   if (own_done) state_nxt = S_SHIFT;
            S_SHIFT: if (own_done) state_nxt = (round_idx < nr) ? S_MIX : S_ARK;
            S_MIX:   if (own_done) state_nxt = S_ARK;
            S_ARK: if (own_done) begin
                if (round_idx < nr) begin
                    state_nxt = S_SUB;
                    idx_nxt   = round_idx + 4'd1;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (wd_expired)
            state_nxt = S_ERR;
    end

    assign wd_clear = (state_nxt != state);

    aes_step_watchdog #(.W(WD_W)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .tick    (step_tick),
        .limit   (WD_LIMIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            round_idx <= 4'd0;
        end else begin
            state     <= state_nxt;
            round_idx <= idx_nxt;
        end
    end

    assign ark_en   = (state == S_ARK0) || (state == S_ARK);
    assign sub_en   = (state == S_SUB);
    assign shift_en = (state == S_SHIFT);
    assign mix_en   = (state == S_MIX);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign error    = (state == S_ERR);

endmodule
